// File: rtl/sr_latch_driver_pkg.sv
// sr_latch_driver_pkg: shared FSM encoding and default timing constants for the SR latch command front-end.
package sr_latch_driver_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 8;
    localparam int EN_CYCLES_DEF       = 2;
    localparam int EN_CNT_W            = 8;

endpackage

// File: rtl/sr_latch_driver_btn_sync_debounce.sv
// sr_latch_driver_btn_sync_debounce: 2-flop synchroniser, stability debounce and rising-edge pulse for one button.
module sr_latch_driver_btn_sync_debounce
    import sr_latch_driver_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_q;

    // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= 2'b00;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            level_q <= level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: turns raw set/reset buttons into mutually exclusive, properly sequenced s/r/en
// drive for a gated SR latch (setup cycle, EN_CYCLES gate pulse, hold cycle).
module sr_latch_driver
    import sr_latch_driver_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int EN_CYCLES       = EN_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic rst_btn,
    output logic s,
    output logic r,
    output logic en,
    output logic busy,
    output logic conflict
);
    state_t              state;
    state_t              state_nxt;
    logic                req_set;
    logic                req_rst;
    logic                pend_set;
    logic                pend_rst;
    logic                cmd_set;
    logic                cmd_nxt;
    logic [EN_CNT_W-1:0] en_cnt;
    logic [EN_CNT_W-1:0] en_cnt_nxt;
    logic                s_nxt;
    logic                r_nxt;
    logic                en_nxt;
    logic                busy_nxt;
    logic                conflict_nxt;

    sr_latch_driver_btn_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (set_btn),
        .rise (req_set)
    );

    sr_latch_driver_btn_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (rst_btn),
        .rise (req_rst)
    );

    // In IDLE every pending flag is either consumed or discarded, so only fresh requests survive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_set <= 1'b0;
            pend_rst <= 1'b0;
        end else begin
            pend_set <= req_set | (pend_set & (state != IDLE));
            pend_rst <= req_rst | (pend_rst & (state != IDLE));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd_set  <= 1'b0;
            en_cnt   <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
            en       <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_nxt;
            cmd_set  <= cmd_nxt;
            en_cnt   <= en_cnt_nxt;
            s        <= s_nxt;
            r        <= r_nxt;
            en       <= en_nxt;
            busy     <= busy_nxt;
            conflict <= conflict_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cmd_nxt    = cmd_set;
        en_cnt_nxt = en_cnt;
        case (state)
            IDLE: begin
                if (pend_set ^ pend_rst) begin
                    state_nxt = SETUP;
                    cmd_nxt   = pend_set;
                end
            end
            SETUP: begin
                state_nxt  = ENABLE;
                en_cnt_nxt = '0;
            end
            ENABLE: begin
                if (en_cnt == EN_CNT_W'(EN_CYCLES - 1)) state_nxt = HOLD;
                else en_cnt_nxt = en_cnt + EN_CNT_W'(1);
            end
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode the upcoming state so they are registered yet aligned with it
    always_comb begin
        busy_nxt     = state_nxt != IDLE;
        s_nxt        = busy_nxt & cmd_nxt;
        r_nxt        = busy_nxt & ~cmd_nxt;
        en_nxt       = state_nxt == ENABLE;
        conflict_nxt = (state == IDLE) & pend_set & pend_rst;
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed and randomised checks of two sr_latch_driver configurations against
// a queue/window based reference model of the button-to-latch command behaviour.
module tb_sr_latch_driver;

    localparam int DA = 8, EA = 2, DB = 2, EB = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_btn = 1'b0;
    logic rst_btn = 1'b0;
    logic [1:0] s, r, en, busy, conflict;

    sr_latch_driver #(.DEBOUNCE_CYCLES(DA), .EN_CYCLES(EA)) dut_a (
        .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .rst_btn(rst_btn),
        .s(s[0]), .r(r[0]), .en(en[0]), .busy(busy[0]), .conflict(conflict[0])
    );

    sr_latch_driver #(.DEBOUNCE_CYCLES(DB), .EN_CYCLES(EB)) dut_b (
        .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .rst_btn(rst_btn),
        .s(s[1]), .r(r[1]), .en(en[1]), .busy(busy[1]), .conflict(conflict[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model; channel index = instance*2 + (0 set, 1 reset)
    int dcy[2] = '{DA, DB};
    int ecy[2] = '{EA, EB};
    bit raw_q[4][$];
    bit win[4][$];
    bit lvl[4], rose[4], pend[4];
    int pos[2];
    bit cmd[2], mconf[2];

    int busy_cyc[2], s_cyc[2], en_cyc[2], conf_cnt[2], seq_cnt[2], rseq_cnt[2], idle_run[2], last_gap[2];
    bit p_busy[2], p_s[2], p_r[2], p_en[2];

    task automatic model_reset(input int i);
        for (int c = 0; c < 2; c++) begin
            raw_q[i*2+c].delete();
            win[i*2+c].delete();
            lvl[i*2+c] = 0;
            rose[i*2+c] = 0;
            pend[i*2+c] = 0;
        end
        pos[i] = -1;
        cmd[i] = 0;
        mconf[i] = 0;
    endtask

    task automatic model_step(input int i);
        bit b[2];
        b[0] = set_btn;
        b[1] = rst_btn;
        mconf[i] = 0;
        if (pos[i] >= 0) begin
            pos[i]++;
            if (pos[i] > ecy[i] + 1) pos[i] = -1;
            for (int c = 0; c < 2; c++) pend[i*2+c] |= rose[i*2+c];
        end else begin
            if (pend[i*2] && pend[i*2+1]) mconf[i] = 1;
            else if (pend[i*2] || pend[i*2+1]) begin
                pos[i] = 0;
                cmd[i] = pend[i*2];
            end
            for (int c = 0; c < 2; c++) pend[i*2+c] = rose[i*2+c];
        end
        for (int c = 0; c < 2; c++) begin
            int ch;
            bit smp, all_diff;
            ch = i*2 + c;
            raw_q[ch].push_back(b[c]);
            if (raw_q[ch].size() > 3) void'(raw_q[ch].pop_front());
            smp = (raw_q[ch].size() == 3) ? raw_q[ch][0] : 1'b0;
            win[ch].push_back(smp);
            if (win[ch].size() > dcy[i]) void'(win[ch].pop_front());
            rose[ch] = 0;
            if (win[ch].size() == dcy[i]) begin
                all_diff = 1;
                for (int k = 0; k < win[ch].size(); k++) if (win[ch][k] == lvl[ch]) all_diff = 0;
                if (all_diff) begin
                    lvl[ch] = ~lvl[ch];
                    rose[ch] = lvl[ch];
                    win[ch].delete();
                end
            end
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            busy_cyc[i] = 0; s_cyc[i] = 0; en_cyc[i] = 0; conf_cnt[i] = 0;
            seq_cnt[i] = 0; rseq_cnt[i] = 0; last_gap[i] = -1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) if (!rst_n) model_reset(i); else model_step(i);
        #1;
        for (int i = 0; i < 2; i++) begin
            bit mb, men;
            mb = pos[i] >= 0;
            men = pos[i] >= 1 && pos[i] <= ecy[i];
            check($sformatf("busy%0d", i), busy[i], mb);
            check($sformatf("s%0d", i), s[i], mb & cmd[i]);
            check($sformatf("r%0d", i), r[i], mb & ~cmd[i]);
            check($sformatf("en%0d", i), en[i], men);
            check($sformatf("conflict%0d", i), conflict[i], mconf[i]);
            check($sformatf("s_and_r%0d", i), s[i] & r[i], 0);
            if (en[i] && p_en[i]) check($sformatf("sr_hold%0d", i), {s[i], r[i]}, {p_s[i], p_r[i]});
            busy_cyc[i] += busy[i];
            s_cyc[i] += s[i];
            en_cyc[i] += en[i];
            conf_cnt[i] += conflict[i];
            if (busy[i] && !p_busy[i]) begin
                seq_cnt[i]++;
                if (r[i]) rseq_cnt[i]++;
                last_gap[i] = idle_run[i];
                idle_run[i] = 0;
            end
            if (!busy[i]) idle_run[i]++;
            p_busy[i] = busy[i]; p_s[i] = s[i]; p_r[i] = r[i]; p_en[i] = en[i];
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            idle_run[i] = 1000;
        end
        clear_stats();
        ticks(3);
        rst_n = 1'b1;
        ticks(20);

        // clean set: latency, pulse width and busy window
        clear_stats();
        set_btn = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!en[0] && n < 60);
        check("latency", n, 2 + DA + 3);
        ticks(30);
        check("clean_en_cycles", en_cyc[0], EA);
        check("clean_busy_cycles", busy_cyc[0], EA + 2);
        check("clean_s_cycles", s_cyc[0], EA + 2);
        check("clean_rseq", rseq_cnt[0], 0);
        set_btn = 1'b0;
        ticks(30);

        // bounce rejection on the slow-debounce instance
        clear_stats();
        for (int k = 0; k < 40; k++) begin
            set_btn = (k % 5) < 3;
            tick();
        end
        set_btn = 1'b0;
        ticks(30);
        check("bounce_busy", busy_cyc[0], 0);
        check("bounce_s", s_cyc[0], 0);

        // simultaneous requests
        clear_stats();
        set_btn = 1'b1;
        rst_btn = 1'b1;
        ticks(30);
        check("conflict_pulses", conf_cnt[0], 1);
        check("conflict_en", en_cyc[0], 0);
        check("conflict_busy", busy_cyc[0], 0);
        check("conflict_pulses_b", conf_cnt[1], 1);
        set_btn = 1'b0;
        rst_btn = 1'b0;
        ticks(30);

        // reset request queued behind a running set sequence
        clear_stats();
        set_btn = 1'b1;
        ticks(3);
        rst_btn = 1'b1;
        ticks(40);
        check("queued_seqs", seq_cnt[0], 2);
        check("queued_rseq", rseq_cnt[0], 1);
        check("queued_gap", last_gap[0], 1);
        set_btn = 1'b0;
        rst_btn = 1'b0;
        ticks(40);

        // merge: on the fast instance two extra set edges land in one busy window
        clear_stats();
        for (int k = 0; k < 17; k++) begin
            set_btn = (k < 4) || (k >= 7 && k < 10) || (k >= 13 && k < 16);
            tick();
        end
        set_btn = 1'b0;
        ticks(50);
        check("merge_seqs", seq_cnt[1], 2);
        check("merge_rseq", rseq_cnt[1], 0);

        // asynchronous reset in the middle of the gate pulse
        clear_stats();
        set_btn = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!en[0] && n < 60);
        check("pre_reset_en", en[0], 1);
        rst_n = 1'b0;
        #1;
        check("async_s", s[0], 0);
        check("async_r", r[0], 0);
        check("async_en", en[0], 0);
        check("async_busy", busy[0], 0);
        check("async_conflict", conflict[0], 0);
        set_btn = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        clear_stats();
        ticks(30);
        check("post_reset_busy", busy_cyc[0], 0);

        // randomised run
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 99) < 3) set_btn = ~set_btn;
            if ($urandom_range(0, 99) < 3) rst_btn = ~rst_btn;
            if ($urandom_range(0, 2999) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            tick();
        end
        rst_n = 1'b1;
        ticks(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Command front-end that feeds the gated SR latch stage.
- Converts two raw, asynchronous push-button requests (set, reset) into clean, mutually exclusive s/r/en stimulus.
- Performs synchronisation, debounce, edge detection, conflict resolution and enable-pulse sequencing, so the latch never sees s=r=1 and never sees s/r change while en=1.

Parameters:
- DEBOUNCE_CYCLES, 8: consecutive stable synchronised samples required before the debounced level changes; legal range 2..65535.
- EN_CYCLES, 2: width of the en pulse in clock cycles; legal range 1..255.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- set_btn  in  1  raw set request, asynchronous to clk, may bounce.
- rst_btn  in  1  raw reset request, asynchronous to clk, may bounce.
- s  out  1  set drive to latch.
- r  out  1  reset drive to latch.
- en  out  1  gate enable to latch.
- busy  out  1  high while a command sequence is in progress (state != IDLE).
- conflict  out  1  one-cycle pulse when simultaneous set and reset requests are discarded.

Behaviour:
- Reset: clk and rst_n as stated in "Already decided".
  - rst_n low asynchronously clears every flop: synchronisers, debounce counters, debounced levels, pending flags, FSM.
  - While reset is asserted and after release: s=0, r=0, en=0, busy=0, conflict=0, FSM=IDLE.
  - Reset mid-sequence aborts immediately; no partial en pulse resumes.
- Synchronise: each button passes through a 2-flop synchroniser. 2 cycles of latency before the debounce stage.
- Debounce, per channel:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If the synchronised sample equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Edge detect: a 0->1 transition of a debounced level raises a one-cycle req_set or req_rst. Release (1->0) generates nothing.
- Pending capture, one-deep flag per channel:
  - req_set sets pend_set and req_rst sets pend_rst.
  - A flag is cleared when the FSM consumes it.
  - A repeat request of the same type while pending is merged and not counted.
- Conflict:
  - If pend_set and pend_rst are both 1 in IDLE, both flags clear, conflict pulses for 1 cycle and no sequence starts.
  - Requests on the same cycle as consumption are captured for the next sequence.
- FSM states and transitions (s/r shown for a set command; reset command mirrors it on r):
  - IDLE: s=r=en=0. Exactly one pend flag set -> SETUP, consuming that flag and registering cmd.
  - SETUP: s=cmd_set, r=cmd_rst, en=0, duration 1 cycle -> ENABLE. This gives one cycle of data setup before the gate opens.
  - ENABLE: s/r held, en=1 for exactly EN_CYCLES cycles. Uses an 8-bit count; on the last cycle -> HOLD.
  - HOLD: en=0, s/r still held, duration 1 cycle of hold after the gate closes -> IDLE with s=r=0.
- Output rules:
  - All outputs are registered; no combinational path from buttons to outputs.
  - s and r are never both 1.
  - en=1 only in ENABLE.
  - busy=1 in SETUP, ENABLE and HOLD.
- Latency: a clean button edge reaches en=1 in 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) + 1 (IDLE->SETUP) + 1 cycles. The bench checks this exact figure.
- Back-to-back: a request pending at HOLD exit starts SETUP on the cycle after returning to IDLE, with one IDLE cycle guaranteed.

Decomposition:
- Shared package holds:
  - FSM state enum: IDLE, SETUP, ENABLE, HOLD (2 bits).
  - Default constants for DEBOUNCE_CYCLES and EN_CYCLES.
- Natural sub-module: btn_sync_debounce, covering the 2-flop synchroniser, debounce counter and rising-edge pulse. It is instantiated twice, for set and reset.
- FSM, pending flags and conflict logic live in the top level.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-ENABLE -> s=r=en=busy=0 within the same cycle (async); FSM returns to IDLE after release.
- Clean set, DEBOUNCE_CYCLES=8 and EN_CYCLES=2: set_btn 0->1 held -> en high exactly 13 cycles after the edge, for 2 cycles.
  - s=1 from one cycle before en until one cycle after en.
  - r=0 throughout and busy high for 4 cycles.
- Bounce rejection: set_btn pulses of 3 cycles high / 2 cycles low for 40 cycles, then low -> no en, s stays 0, busy stays 0.
- Simultaneous request: set_btn and rst_btn rise on the same cycle -> one conflict pulse, no en, and s=r=0 throughout.
- Queued command: rst_btn edge debounces while a set sequence is in ENABLE -> after HOLD, one IDLE cycle, then a reset sequence with r=1 and s=0.
- Merge and invariant: two set edges during one busy window -> exactly one further set sequence. A randomised run of 10k cycles never shows s&r=1 and never shows s/r change while en=1.
